uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters (e.g. order-ack path, telemetry, debug console).
- Round-robin arbitration at message granularity: a grant is held from the first byte to the byte marked last, so messages never interleave on the wire.
- Sits between the requesters and the UART transmitter, driving its data/start inputs and pacing on its busy output.
- Releases a stalled requester after a programmable gap timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_TIMEOUT, 1_250_000, maximum clk cycles a granted requester may leave valid low mid-message before its grant is revoked (10 ms at 125 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  marks final byte of a message.
- req_ready  out  NUM_REQ  byte accepted when valid&ready.
- tx_data  out  8  to transmitter data input.
- tx_start  out  1  one-cycle start strobe to transmitter.
- tx_busy  in  1  transmitter busy.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout.
- timeout_id  out  3  index of the revoked requester; held until the next timeout.

Behaviour:
- Reset values:
  - state=ARB; grant=0; rr_ptr=0; req_ready=0; tx_start=0; tx_data=0; timeout_pulse=0; timeout_id=0; gap counter=0.
  - Reset mid-byte abandons the message. The transmitter is reset by the same rst.
- States: ARB, LOAD, WAIT_BUSY, WAIT_DONE.
- ARB:
  - Waits for tx_busy=0.
  - Scans req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - On a hit at index i: grant<=onehot(i), go to LOAD.
  - No hit: stay in ARB. Arbitration costs 1 cycle.
- LOAD:
  - req_ready[g]=1 (combinational from state and grant); all other ready bits 0.
  - If req_valid[g]:
    - tx_start=1 and tx_data=req_data[g] in the same cycle (both combinational).
    - Latch last_flag<=req_last[g]; go to WAIT_BUSY.
  - Else the gap counter increments. When it reaches GAP_TIMEOUT-1:
    - timeout_pulse=1; timeout_id=g; grant<=0; rr_ptr<=g+1 (wrapping); go to ARB.
  - Gap counter clears on every accepted byte and on entry to ARB.
- WAIT_BUSY: go to WAIT_DONE on tx_busy=1. The transmitter asserts busy the cycle after start.
- WAIT_DONE: on tx_busy=0:
  - last_flag=1: grant<=0, rr_ptr<=g+1 (wrapping), go to ARB.
  - last_flag=0: go to LOAD.
- Throughput: per byte, at most 3 cycles of controller overhead beyond the transmitter's frame time.
- tx_start is never asserted while tx_busy=1 or outside LOAD.
- Boundary conditions:
  - Single-byte message (valid and last in one cycle) is legal.
  - req_valid/req_data changes on non-granted requesters are ignored.
  - All requesters valid: service order 0,1,2,3,0,…
  - A requester that deasserts valid in ARB before being granted loses its turn with no side effects.
  - Timeout fires only in LOAD, never while a byte is on the wire.
  - Simultaneous last byte and a timeout count are impossible, since the counter is cleared on acceptance.

Decomposition:
- Shared package uart_pkg holds the state encoding localparams (ARB, LOAD, WAIT_BUSY, WAIT_DONE) and the requester-index width function clog2(NUM_REQ).
- One natural sub-module: rr_pick, a combinational round-robin priority picker (valid vector + pointer -> one-hot + index + hit), reusable by other arbiters.

Test Plan:
1. Bench setup: uart_tx attached with CLK_FREQ=8, BAUD_RATE=2 (4 clks/bit).
2. Req0 sends 0x41 with last=1 -> exactly one tx_start with tx_data=0x41. Serial line shows start, 10000010 LSB-first, stop. grant returns to 0; rr_ptr=1.
3. Req1 sends {0xAA,0x55,0x0F(last)} while req2 holds a 2-byte message valid -> wire order AA,55,0F, then req2's bytes. No interleave. grant=0010 throughout req1's message.
4. All four requesters send 1-byte messages 0x10..0x13 simultaneously and repeatedly -> service order 0,1,2,3,0. Each tx_start spaced ≥ one 40-cycle frame. Never two starts with tx_busy=1.
5. GAP_TIMEOUT=20: req3 sends 0x01 (last=0), then holds valid low -> exactly 20 cycles in LOAD, then timeout_pulse for 1 cycle, timeout_id=3, grant=0. Pending req0 is granted next.
6. Assert rst for 1 cycle during req2's second data bit -> next cycle grant=0, req_ready=0, tx_start=0, uart_tx=1. A new request after reset is granted starting from requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter and its helpers.
//   arb_state_t : controller state encoding (ARB, LOAD, WAIT_BUSY, WAIT_DONE)
//   clog2()     : ceiling log2 with a floor of 1, usable in constant context
//                 to size requester-index and counter fields.
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      ARB       = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   // Width needed to hold values 0..n-1; never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 32'sd0;
      for (int v = n - 32'sd1; v > 32'sd0; v = v >>> 1) begin
         r = r + 32'sd1;
      end
      return (r < 32'sd1) ? 32'sd1 : r;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Starting at index ptr and
// wrapping modulo N, selects the first set bit of valid.
// Ports:
//   valid  [N-1:0]  request vector
//   ptr    [IW-1:0] highest-priority index for this pick (must be < N)
//   onehot [N-1:0]  one-hot of the winner, 0 when no request
//   idx    [IW-1:0] binary index of the winner, 0 when no request
//   hit             at least one request was found
// ---------------------------------------------------------------------------
module rr_pick
   import uart_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          hit
);

   logic [IW-1:0] cand_s;

   // Walk from lowest to highest priority so the last hit written wins,
   // i.e. the candidate closest to ptr.
   always_comb begin
      onehot = '0;
      idx    = '0;
      hit    = 1'b0;
      cand_s = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand_s = IW'((int'(ptr) + k) % N);
         if (valid[cand_s]) begin
            onehot         = '0;
            onehot[cand_s] = 1'b1;
            idx            = cand_s;
            hit            = 1'b1;
         end else begin
            hit = hit;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte-stream requesters with
// round-robin arbitration at message granularity: once granted, a requester
// keeps the transmitter until it hands over a byte flagged last, or until it
// leaves valid low for GAP_TIMEOUT cycles while the controller waits for data.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/data/last/ready  per-requester byte handshake (data i at [8i+7:8i])
//   tx_data, tx_start          byte and one-cycle start strobe to the transmitter
//   tx_busy                    transmitter busy (asserts the cycle after start)
//   grant                      one-hot current owner, 0 when idle
//   timeout_pulse, timeout_id  revocation strobe and index of revoked owner
// ---------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int GAP_TIMEOUT = 1_250_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   timeout_pulse,
   output logic [2:0]             timeout_id
);

   localparam int IW = clog2(NUM_REQ);
   localparam int CW = clog2(GAP_TIMEOUT);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TIMEOUT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

   arb_state_t          state_r, state_s;
   logic [NUM_REQ-1:0]  grant_r, grant_s;
   logic [IW-1:0]       g_idx_r, g_idx_s;
   logic [IW-1:0]       rr_ptr_r, rr_ptr_s;
   logic                last_flag_r, last_flag_s;
   logic [CW-1:0]       gap_cnt_r, gap_cnt_s;
   logic                timeout_pulse_r, timeout_pulse_s;
   logic [2:0]          timeout_id_r, timeout_id_s;

   logic [NUM_REQ-1:0]  pick_onehot_s;
   logic [IW-1:0]       pick_idx_s;
   logic                pick_hit_s;

   logic                g_valid_s;
   logic                g_last_s;
   logic [7:0]          g_data_s;
   logic [IW-1:0]       rr_next_s;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .valid  (req_valid),
      .ptr    (rr_ptr_r),
      .onehot (pick_onehot_s),
      .idx    (pick_idx_s),
      .hit    (pick_hit_s)
   );

   // Route the granted requester's handshake signals; other requesters are ignored.
   always_comb begin
      g_valid_s = 1'b0;
      g_last_s  = 1'b0;
      g_data_s  = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_r[i]) begin
            g_valid_s = req_valid[i];
            g_last_s  = req_last[i];
            g_data_s  = req_data[8*i +: 8];
         end else begin
            g_data_s = g_data_s;
         end
      end
   end

   // Pointer value that puts the requester after the current owner first.
   always_comb begin
      if (g_idx_r == IDX_LAST) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = g_idx_r + IW'(1);
      end
   end

   // Next-state and handshake/transmitter outputs.
   always_comb begin
      state_s         = state_r;
      grant_s         = grant_r;
      g_idx_s         = g_idx_r;
      rr_ptr_s        = rr_ptr_r;
      last_flag_s     = last_flag_r;
      gap_cnt_s       = gap_cnt_r;
      timeout_pulse_s = 1'b0;
      timeout_id_s    = timeout_id_r;
      req_ready       = '0;
      tx_start        = 1'b0;
      tx_data         = 8'h00;
      case (state_r)
         ARB: begin
            gap_cnt_s = '0;
            grant_s   = '0;
            if (!tx_busy && pick_hit_s) begin
               grant_s = pick_onehot_s;
               g_idx_s = pick_idx_s;
               state_s = LOAD;
            end else begin
               state_s = ARB;
            end
         end
         LOAD: begin
            req_ready = grant_r;
            if (g_valid_s) begin
               tx_start    = 1'b1;
               tx_data     = g_data_s;
               last_flag_s = g_last_s;
               gap_cnt_s   = '0;
               state_s     = WAIT_BUSY;
            end else if (gap_cnt_r == GAP_LAST) begin
               // Owner stalled mid-message: revoke and move past it.
               timeout_pulse_s = 1'b1;
               timeout_id_s    = 3'(g_idx_r);
               grant_s         = '0;
               rr_ptr_s        = rr_next_s;
               gap_cnt_s       = '0;
               state_s         = ARB;
            end else begin
               gap_cnt_s = gap_cnt_r + CW'(1);
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_s = WAIT_DONE;
            end else begin
               state_s = WAIT_BUSY;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_flag_r) begin
                  grant_s  = '0;
                  rr_ptr_s = rr_next_s;
                  state_s  = ARB;
               end else begin
                  state_s = LOAD;
               end
            end else begin
               state_s = WAIT_DONE;
            end
         end
         default: begin
            state_s   = ARB;
            grant_s   = '0;
            gap_cnt_s = '0;
         end
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= ARB;
         grant_r         <= '0;
         g_idx_r         <= '0;
         rr_ptr_r        <= '0;
         last_flag_r     <= 1'b0;
         gap_cnt_r       <= '0;
         timeout_pulse_r <= 1'b0;
         timeout_id_r    <= 3'd0;
      end else begin
         state_r         <= state_s;
         grant_r         <= grant_s;
         g_idx_r         <= g_idx_s;
         rr_ptr_r        <= rr_ptr_s;
         last_flag_r     <= last_flag_s;
         gap_cnt_r       <= gap_cnt_s;
         timeout_pulse_r <= timeout_pulse_s;
         timeout_id_r    <= timeout_id_s;
      end
   end

   assign grant         = grant_r;
   assign timeout_pulse = timeout_pulse_r;
   assign timeout_id    = timeout_id_r;

endmodule
